uart_rx: RTL and testbench

- Serial receiver for the UART link: 8N1 by default, LSB first, 16x oversampled by the shared `b_tick` baud generator.
- Counterpart of the stopwatch's `uart_tx`. Feeds received command bytes (run/stop/clear, etc.) to the control logic.
- Synchronises the asynchronous `rx` pin and validates the start bit at mid-bit.
- Samples each data bit and the stop bit at its centre, then presents the byte with a one-cycle `rx_done` strobe.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 147 ++++++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry.
package uart_pkg;

    // Default frame geometry, shared by the transmitter and the receiver
    localparam int DATA_BITS_DEF  = 8;
    localparam int OVERSAMPLE_DEF = 16;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable
// reset value so it can match the idle level of the line it guards.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage shift towards the clk domain; both stages take the idle value on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: LSB-first frames with one start and one stop bit, oversampled
// by b_tick. Start bit is validated at mid-bit, every later bit is sampled at
// its centre, and the FSM returns to IDLE at mid-stop so back-to-back frames work.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rx_s;

    uart_state_t          state_q,     state_d;
    logic [TW-1:0]        tick_cnt_q,  tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q,     shreg_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 rx_done_q,   rx_done_d;
    logic                 rx_busy_q,   rx_busy_d;
    logic                 frame_err_q, frame_err_d;

    // The line idles high, so the synchroniser resets to 1 to avoid a false start
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Next-state logic: everything advances on b_tick only; strobes self-clear
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_busy_d   = rx_busy_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        if (b_tick) begin
            case (state_q)
                IDLE: begin
                    rx_busy_d = 1'b0;
                    if (!rx_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                        rx_busy_d  = 1'b1;
                    end
                end
                START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        if (!rx_s) begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            // Glitch shorter than half a bit: drop it quietly
                            state_d   = IDLE;
                            rx_busy_d = 1'b0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        shreg_d    = {rx_s, shreg_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        if (rx_s) begin
                            rx_data_d = shreg_q;
                            rx_done_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        state_d   = IDLE;
                        rx_busy_d = 1'b0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rx_busy_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset aborts any frame without a strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            rx_busy_q   <= rx_busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: serial frames are driven bit by bit against
// the same b_tick the receiver uses; a monitor counts strobes and logs bytes.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       b_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    int div     = 16;
    int div_cnt = 0;

    int         done_cnt  = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    int         long_cnt  = 0;
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] data_q[$];

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .b_tick    (b_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick generator: one pulse every div clocks
    initial b_tick = 1'b0;
    always @(posedge clk) begin
        if (div_cnt >= div - 1) begin
            div_cnt <= 0;
            b_tick  <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1;
            b_tick  <= 1'b0;
        end
    end

    // Strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            data_q.push_back(rx_data);
        end
        if (frame_err) ferr_cnt++;
        if (rx_done && frame_err) both_cnt++;
        if ((rx_done && prev_done) || (frame_err && prev_ferr)) long_cnt++;
        prev_done = rx_done;
        prev_ferr = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!b_tick);
        end
        #1;
    endtask

    task automatic drive_bits(input logic [9:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            rx = pat[i];
            wait_ticks(16);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bits({stop_bit, d, 1'b0}, 10);
    endtask

    // Watchdog so a stuck run still reports and stops
    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, f0, base;
        logic [9:0] pat;
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset rx_data", rx_data, 0);
        check("reset rx_done", rx_done, 0);
        check("reset rx_busy", rx_busy, 0);
        check("reset frame_err", frame_err, 0);
        wait_ticks(4);

        // Single frame 0x55 at 16 clk per b_tick
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b1);
        wait_ticks(4);
        $display("frame 0x55: rx_data=%0h done=%0d", rx_data, done_cnt - d0);
        check("55 done count", done_cnt - d0, 1);
        check("55 rx_data", rx_data, 8'h55);
        check("55 ferr count", ferr_cnt - f0, 0);
        check("55 busy after", rx_busy, 0);

        div = 4;
        wait_ticks(4);

        // False start: low for 4 ticks only
        d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(24);
        $display("false start: done=%0d ferr=%0d busy=%0b", done_cnt - d0, ferr_cnt - f0, rx_busy);
        check("false start done", done_cnt - d0, 0);
        check("false start ferr", ferr_cnt - f0, 0);
        check("false start busy", rx_busy, 0);
        send_frame(8'hC3, 1'b1);
        wait_ticks(4);
        $display("frame 0xC3: rx_data=%0h", rx_data);
        check("C3 done count", done_cnt - d0, 1);
        check("C3 rx_data", rx_data, 8'hC3);

        // Framing error after a good byte
        send_frame(8'h12, 1'b1);
        wait_ticks(4);
        check("12 rx_data", rx_data, 8'h12);
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0);
        rx = 1'b1;
        wait_ticks(40);
        $display("frame 0xA5 bad stop: ferr=%0d done=%0d rx_data=%0h", ferr_cnt - f0, done_cnt - d0, rx_data);
        check("A5 ferr count", ferr_cnt - f0, 1);
        check("A5 done count", done_cnt - d0, 0);
        check("A5 rx_data kept", rx_data, 8'h12);
        check("A5 busy after", rx_busy, 0);

        // Back-to-back frames, no idle gap
        d0 = done_cnt; f0 = ferr_cnt; base = data_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        wait_ticks(4);
        $display("back-to-back: done=%0d ferr=%0d", done_cnt - d0, ferr_cnt - f0);
        check("b2b done count", done_cnt - d0, 3);
        check("b2b ferr count", ferr_cnt - f0, 0);
        if (data_q.size() >= base + 3) begin
            check("b2b byte0", data_q[base], 8'h00);
            check("b2b byte1", data_q[base+1], 8'hFF);
            check("b2b byte2", data_q[base+2], 8'h81);
        end else begin
            check("b2b queue size", data_q.size(), base + 3);
        end

        // Reset during data bit 3 of 0x3C
        d0 = done_cnt; f0 = ferr_cnt;
        pat = {1'b1, 8'h3C, 1'b0};
        drive_bits(pat, 4);
        rx = pat[4];
        wait_ticks(8);
        check("3C busy mid-frame", rx_busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        $display("reset mid-frame: rx_data=%0h busy=%0b", rx_data, rx_busy);
        check("midrst rx_data", rx_data, 0);
        check("midrst rx_done", rx_done, 0);
        check("midrst rx_busy", rx_busy, 0);
        check("midrst frame_err", frame_err, 0);
        rx = 1'b1;
        wait_ticks(200);
        check("midrst done count", done_cnt - d0, 0);
        check("midrst ferr count", ferr_cnt - f0, 0);
        send_frame(8'h7E, 1'b1);
        wait_ticks(4);
        $display("frame 0x7E: rx_data=%0h", rx_data);
        check("7E done count", done_cnt - d0, 1);
        check("7E rx_data", rx_data, 8'h7E);

        // Loopback-style sweep of every byte value, b_tick every clock
        div = 1;
        wait_ticks(20);
        d0 = done_cnt; f0 = ferr_cnt; base = data_q.size();
        for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1);
        wait_ticks(20);
        $display("sweep: done=%0d ferr=%0d", done_cnt - d0, ferr_cnt - f0);
        check("sweep done count", done_cnt - d0, 256);
        check("sweep ferr count", ferr_cnt - f0, 0);
        for (int b = 0; b < 256 && base + b < data_q.size(); b++)
            check($sformatf("sweep byte %0d", b), data_q[base+b], b);

        check("strobes overlapping", both_cnt, 0);
        check("strobes wider than 1 clk", long_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
